// File: rtl/freq_div_pkg.sv
// Shared definitions for the programmable frequency divider.
// Contents:
//   state_t      - divider FSM states (IDLE, RUN)
//   DEF_MIN_DIV  - default smallest divisor honoured by the divider
//   DIV_*        - the four standard divisors issued by the divisor selector
package freq_div_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_MIN_DIV = 2;

  localparam logic [31:0] DIV_512K  = 32'd512000;
  localparam logic [31:0] DIV_1024K = 32'd1024000;
  localparam logic [31:0] DIV_2048K = 32'd2048000;
  localparam logic [31:0] DIV_4096K = 32'd4096000;

endpackage

// File: rtl/freq_div_n_if.sv
// Divider control/status bundle between the divisor selector (master) and the
// frequency divider (slave).
// Signals:
//   en        master->slave  run enable
//   DivN      master->slave  requested divisor
//   clk_out   slave->master  divided square wave (registered)
//   tick      slave->master  one-cycle pulse in the last cycle of each period
//   running   slave->master  high while the divider is in RUN
//   active_n  slave->master  divisor currently in use, after clamping
interface freq_div_n_if #(
  parameter int WIDTH = 32
);

  logic             en;
  logic [WIDTH-1:0] DivN;
  logic             clk_out;
  logic             tick;
  logic             running;
  logic [WIDTH-1:0] active_n;

  modport master (
    output en,
    output DivN,
    input  clk_out,
    input  tick,
    input  running,
    input  active_n
  );

  modport slave (
    input  en,
    input  DivN,
    output clk_out,
    output tick,
    output running,
    output active_n
  );

endinterface

// File: rtl/div_counter.sv
// Wrap counter for the frequency divider. The count register runs
// 0..limit-1; clear forces it to 0, inc advances it with wrap, and with
// neither asserted it holds.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   clear      force the count to 0 on the next edge (priority over inc)
//   inc        advance the count, wrapping after limit-1
//   limit      current period length
//   cnt_next   value the count register takes on the next edge
//   wrap       the count is at limit-1 (last cycle of the period)
module div_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] cnt_next,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt_r;

  assign wrap = (cnt_r == (limit - WIDTH'(1)));

  // Next count: clear beats increment; increment wraps to 0 on the last cycle.
  always_comb begin
    cnt_next = cnt_r;
    if (clear) begin
      cnt_next = '0;
    end else if (inc) begin
      if (wrap) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt_r + WIDTH'(1);
      end
    end else begin
      cnt_next = cnt_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_next;
    end
  end

endmodule

// File: rtl/freq_div_n.sv
// Programmable frequency divider. Counts clk cycles and produces a registered
// divided square wave (clk_out) plus a one-cycle tick in the last cycle of
// every period. The requested divisor is clamped up to MIN_DIV.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   freq_div_n_if slave: en/DivN in, clk_out/tick/running/active_n out
// Build option:
//   FREQ_DIV_SHADOW_EN defined   - a new divisor is loaded only at the wrap
//                                  edge, so the current period always completes.
//   FREQ_DIV_SHADOW_EN undefined - any change of the clamped divisor restarts
//                                  the period on the next edge.
module freq_div_n
  import freq_div_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MIN_DIV = DEF_MIN_DIV
) (
  input  logic          clk,
  input  logic          rst,
  freq_div_n_if.slave   bus
);

  localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] x);
    if (x < MIN_DIV_W) begin
      return MIN_DIV_W;
    end else begin
      return x;
    end
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] active_r;
  logic [WIDTH-1:0] active_next_s;
  logic [WIDTH-1:0] div_req_s;
  logic [WIDTH-1:0] cnt_next_s;
  logic             wrap_s;
  logic             cnt_clear_s;
  logic             cnt_inc_s;
  logic             run_next_s;
  logic             clk_out_next_s;
  logic             tick_next_s;
  logic             clk_out_r;
  logic             tick_r;
  logic             running_r;

  assign div_req_s = clamp(bus.DivN);

  div_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear_s),
    .inc      (cnt_inc_s),
    .limit    (active_r),
    .cnt_next (cnt_next_s),
    .wrap     (wrap_s)
  );

  // FSM next state, divisor shadow and counter control.
  always_comb begin
    state_next_s  = state_r;
    active_next_s = active_r;
    cnt_clear_s   = 1'b1;
    cnt_inc_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.en) begin
          state_next_s  = RUN;
          active_next_s = div_req_s;
        end else begin
          state_next_s  = IDLE;
        end
      end
      RUN: begin
        if (!bus.en) begin
          // Leaving RUN wins over a simultaneous wrap: no divisor reload.
          state_next_s = IDLE;
        end else begin
          state_next_s = RUN;
`ifdef FREQ_DIV_SHADOW_EN
          cnt_clear_s = 1'b0;
          cnt_inc_s   = 1'b1;
          if (wrap_s) begin
            active_next_s = div_req_s;
          end else begin
            active_next_s = active_r;
          end
`else
          if (div_req_s != active_r) begin
            // Divisor changed: restart the period with the new value.
            active_next_s = div_req_s;
          end else begin
            cnt_clear_s = 1'b0;
            cnt_inc_s   = 1'b1;
            // Reload at the wrap as well; the value is unchanged on this path.
            if (wrap_s) begin
              active_next_s = div_req_s;
            end else begin
              active_next_s = active_r;
            end
          end
`endif
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output decode on the post-edge count/divisor so the flops present the
  // values that belong to the cycle being entered.
  always_comb begin
    run_next_s     = (state_next_s == RUN);
    clk_out_next_s = run_next_s && (cnt_next_s < (active_next_s >> 1));
    tick_next_s    = run_next_s && (cnt_next_s == (active_next_s - WIDTH'(1)));
  end

  // State, shadow divisor and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      active_r  <= '0;
      clk_out_r <= 1'b0;
      tick_r    <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      active_r  <= active_next_s;
      clk_out_r <= clk_out_next_s;
      tick_r    <= tick_next_s;
      running_r <= run_next_s;
    end
  end

  assign bus.clk_out  = clk_out_r;
  assign bus.tick     = tick_r;
  assign bus.running  = running_r;
  assign bus.active_n = active_r;

endmodule

// File: tb/tb_freq_div_n.sv
// Scoreboard bench for freq_div_n. The driver applies inputs on the falling
// edge, advances a period-position reference model and queues the outputs
// expected after the next rising edge; the monitor pops and compares after
// every rising edge.
module tb_freq_div_n;
  import freq_div_pkg::*;

  typedef struct packed {
    logic        clk_out;
    logic        tick;
    logic        running;
    logic [31:0] active_n;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  freq_div_n_if #(.WIDTH(32)) bus ();

  freq_div_n #(
    .WIDTH   (32),
    .MIN_DIV (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t   q[$];
  int     vectors     = 0;
  int     miscompares = 0;

  // Reference model: an output period is described by the edge index at which
  // it started and its length; position = edges elapsed since that start.
  longint edge_idx = 0;
  longint m_start  = 0;
  longint m_n      = 0;
  bit     m_run    = 1'b0;

  function automatic longint clampv(input logic [31:0] d);
    if (d < 32'd2) return 64'd2;
    else return longint'(d);
  endfunction

  task automatic cycle(input logic r, input logic e, input logic [31:0] d);
    exp_t   x;
    longint c;
    longint pos;
    @(negedge clk);
    rst      = r;
    bus.en   = e;
    bus.DivN = d;
    c = clampv(d);
    if (r) begin
      m_run = 1'b0;
      m_n   = 0;
    end else if (!m_run) begin
      if (e) begin
        m_run   = 1'b1;
        m_n     = c;
        m_start = edge_idx;
      end
    end else if (!e) begin
      m_run = 1'b0;
    end else begin
      pos = edge_idx - m_start;
`ifdef FREQ_DIV_SHADOW_EN
      if (pos == m_n) begin
        m_start = edge_idx;
        m_n     = c;
      end
`else
      if (c != m_n) begin
        m_start = edge_idx;
        m_n     = c;
      end else if (pos == m_n) begin
        m_start = edge_idx;
      end
`endif
    end
    pos = edge_idx - m_start;
    x.running  = m_run;
    x.clk_out  = m_run && (pos < m_n / 2);
    x.tick     = m_run && (pos == m_n - 1);
    x.active_n = m_n[31:0];
    q.push_back(x);
    edge_idx++;
  endtask

  task automatic run(input int n, input logic e, input logic [31:0] d);
    for (int i = 0; i < n; i++) cycle(1'b0, e, d);
  endtask

  // Monitor: compare DUT outputs against the queued expectation after each edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        vectors++;
        if (bus.clk_out !== x.clk_out || bus.tick !== x.tick ||
            bus.running !== x.running || bus.active_n !== x.active_n) begin
          miscompares++;
          $display("FAIL outputs @%0t: got clk_out=%b tick=%b running=%b active_n=%0d, want clk_out=%b tick=%b running=%b active_n=%0d",
                   $time, bus.clk_out, bus.tick, bus.running, bus.active_n,
                   x.clk_out, x.tick, x.running, x.active_n);
        end
      end
    end
  end

  initial begin
    logic        cur_en;
    logic [31:0] cur_d;
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.DivN = 32'd0;

    // Reset state.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0);

    // Divide by 4, then 5.
    run(13, 1'b1, 32'd4);
    run(2,  1'b0, 32'd4);
    run(16, 1'b1, 32'd5);
    run(1,  1'b0, 32'd5);

    // Divisors below the minimum clamp to 2.
    run(6, 1'b1, 32'd0);
    run(6, 1'b1, 32'd1);
    run(1, 1'b0, 32'd1);

    // Running at 8, switch to 4 while the count is 2.
    run(3,  1'b1, 32'd8);
    run(16, 1'b1, 32'd4);
    run(1,  1'b0, 32'd4);

    // Drop en at count 3 of a divide-by-6 period, then re-enable.
    run(4,  1'b1, 32'd6);
    run(1,  1'b0, 32'd6);
    run(14, 1'b1, 32'd6);

    // Randomized enable and divisor changes.
    cur_en = 1'b1;
    cur_d  = 32'd3;
    for (int i = 0; i < 4000; i++) begin
      cur_en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 24) == 0) cur_d = 32'($urandom_range(0, 12));
      cycle(1'b0, cur_en, cur_d);
    end

    // Asynchronous reset mid-period, between clock edges.
    run(3, 1'b1, 32'd7);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.clk_out !== 1'b0 || bus.tick !== 1'b0 ||
        bus.running !== 1'b0 || bus.active_n !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset: got clk_out=%b tick=%b running=%b active_n=%0d, want all 0",
               bus.clk_out, bus.tick, bus.running, bus.active_n);
    end
    q.delete();
    m_run = 1'b0;
    m_n   = 0;
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, DIV_512K);

    // Long divisor after release: still inside the first high phase.
    run(3000, 1'b1, DIV_512K);

    // Let the monitor drain the queue.
    @(posedge clk);
    #3;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: got %0d pending expectations, want 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
